// File: rtl/fetch_unit_if.sv
// fetch_unit_if: memory read port and decode handshake of the fetch stage
interface fetch_unit_if #(
    parameter int word_size = 8,
    parameter int addr_size = 8
);
    logic [addr_size-1:0] mem_address;
    logic                 mem_write;
    logic [word_size-1:0] mem_data;
    logic [word_size-1:0] instr;
    logic [addr_size-1:0] instr_pc;
    logic                 instr_valid;
    logic                 instr_ready;
    logic                 redirect;
    logic [addr_size-1:0] redirect_pc;
    logic                 halt;

    modport master (
        output mem_address, mem_write, instr, instr_pc, instr_valid,
        input  mem_data, instr_ready, redirect, redirect_pc, halt
    );

    modport slave (
        input  mem_address, mem_write, instr, instr_pc, instr_valid,
        output mem_data, instr_ready, redirect, redirect_pc, halt
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing, one-cycle memory latency tracking and 2-entry instruction buffer
module fetch_unit #(
    parameter int                   word_size = 8,
    parameter int                   addr_size = 8,
    parameter logic [addr_size-1:0] reset_pc  = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);
    typedef enum logic {RUN, HALTED} state_t;

    state_t               state;
    logic [addr_size-1:0] pc;
    logic [addr_size-1:0] inflight_pc;
    logic                 inflight;
    logic [word_size-1:0] word0, word1;
    logic [addr_size-1:0] pc0, pc1;
    logic [1:0]           count;
    logic                 pop, push, issue;
    logic [2:0]           credit;
    logic [1:0]           wr_idx;

    assign bus.mem_address = pc;
    assign bus.mem_write   = 1'b0;
    assign bus.instr       = word0;
    assign bus.instr_pc    = pc0;
    assign bus.instr_valid = count != 2'd0;

    // Issue only when the buffer can absorb every word already owed to it
    always_comb begin
        pop    = (count != 2'd0) & bus.instr_ready;
        push   = inflight & !bus.redirect;
        credit = 3'(count) + 3'(inflight) - 3'(pop);
        issue  = (state == RUN) & !bus.halt & !bus.redirect & (credit < 3'd2);
        wr_idx = count - 2'(pop);
    end

    // PC, in-flight tracking and head-first shift buffer; redirect squashes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            pc          <= reset_pc;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            count       <= 2'd0;
            word0       <= '0;
            word1       <= '0;
            pc0         <= '0;
            pc1         <= '0;
        end else begin
            state    <= bus.halt ? HALTED : RUN;
            inflight <= issue;
            if (issue) begin
                pc          <= pc + addr_size'(1);
                inflight_pc <= pc;
            end
            if (bus.redirect) begin
                pc    <= bus.redirect_pc;
                count <= 2'd0;
            end else begin
                if (pop) begin
                    word0 <= word1;
                    pc0   <= pc1;
                end
                if (push && wr_idx == 2'd0) begin
                    word0 <= bus.mem_data;
                    pc0   <= inflight_pc;
                end
                if (push && wr_idx == 2'd1) begin
                    word1 <= bus.mem_data;
                    pc1   <= inflight_pc;
                end
                count <= count + 2'(push) - 2'(pop);
            end
        end
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 8-bit CPU, sitting directly upstream of the `memory_unit` read port. Each cycle it drives a program-counter address into the memory, which returns data with a one-cycle synchronous latency. It captures each returned word into a 2-entry buffer tagged with its PC and presents it to decode over a valid/ready handshake. The stage supports branch redirect with squash of in-flight and buffered words, and a level-sensitive halt.

## Interface
- `word_size`, 8, instruction/data width; must match memory `word_size`
- `addr_size`, 8, PC and address width
- `reset_pc`, 0, PC value after reset
- `clk`  in  1  single clock, all state updates on rising edge
- `rst_n`  in  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low
- `mem_address`  out  addr_size  address to memory port; equals PC register
- `mem_write`  out  1  constant 0; the fetch stage never writes
- `mem_data`  in  word_size  memory `data_out`; holds the word for the address sampled on the previous edge
- `instr`  out  word_size  buffered instruction at FIFO head
- `instr_pc`  out  addr_size  address the head instruction was fetched from
- `instr_valid`  out  1  head entry present
- `instr_ready`  in  1  decode accepts head this cycle
- `redirect`  in  1  branch/jump taken; takes priority over everything
- `redirect_pc`  in  addr_size  new fetch address
- `halt`  in  1  level; suppresses new issues while high

## Operation
- State: `pc`; `inflight` (1 bit) plus `inflight_pc`; 2-entry FIFO of {word, pc} with `count` 0..2; FSM {RUN, HALTED}.
- The FSM is HALTED whenever `halt`=1 at the edge and returns to RUN when `halt`=0. In HALTED, no issue occurs; in-flight completion and FIFO drain continue normally.
- `pop` = `instr_valid` & `instr_ready`.
- `issue` = RUN & !`halt` & !`redirect` & (`count` + `inflight` − `pop` < 2).
- On an issue edge, the memory samples `mem_address`=`pc`. Then `pc` <= `pc`+1 mod 2^addr_size (255 wraps to 0), `inflight` <= 1, and `inflight_pc` <= `pc`. If there is no issue and no redirect, `pc` holds.
- If `inflight`=1 and there is no redirect at the edge, {`mem_data`, `inflight_pc`} is pushed into the FIFO.
- A simultaneous push and pop is legal at any `count`. The credit rule guarantees a push is never made into a full FIFO after the pop.
- Redirect at an edge:
  - `pc` <= `redirect_pc`, `inflight` <= 0, and `count` <= 0. Any in-flight word and all buffered words are discarded, and a pop in the same cycle is ignored.
  - The next issue, from `redirect_pc`, occurs on the following edge if issue conditions hold.
  - If redirect and halt are both high, `pc` is still updated and nothing is issued.
- While `instr_valid`=1 and `instr_ready`=0, `instr` and `instr_pc` hold stable.
- Decode must not depend on `instr` when `instr_valid`=0; the value is don't-care but is driven 0 at reset.

## Timing
- Reset (async assert, sync-release assumed): `pc`=`mem_address`=`reset_pc`, `mem_write`=0, `instr_valid`=0, `instr`=0, `instr_pc`=0, `count`=0, `inflight`=0, FSM=RUN.
- Edge E0 (first edge with `rst_n`=1 and `halt`=0) issues `reset_pc`.
- Edge E1 pushes that word; `instr_valid`=1 after E1. Fetch-to-valid latency is 2 edges.
- With `instr_ready` held at 1, one instruction is delivered per cycle, with consecutive `instr_pc` values.
- Redirect at edge R: `instr_valid`=0 after R. Edge R+1 issues the target, and the target is valid after R+2, giving a 2-cycle bubble.
- Backpressure: with `instr_ready`=0, the FIFO fills to 2 and `pc` stops at the head PC + 2. When ready returns, issue resumes on that same edge.
- Reset asserted mid-operation clears all state immediately, without waiting for `clk`.

## Test plan
- Reset then free-run, memory[0..3]=A0,A1,A2,A3, `instr_ready`=1: valid rises after the 2nd edge. Delivered (instr_pc, instr) = (0,A0),(1,A1),(2,A2),(3,A3) on consecutive cycles; `mem_write` is always 0.
- Backpressure: hold `instr_ready`=0 from the start.
  - `count` saturates at 2, `mem_address` holds at 2, and `instr`=A0 stays stable.
  - Release ready: the stream continues 0,1,2,3 with no loss or duplication.
- Redirect: during streaming at pc=5, pulse `redirect` with `redirect_pc`=0x40.
  - Valid drops for 2 cycles.
  - The next delivered instr_pc is 0x40, and no word from 5/6 is delivered after the redirect edge.
- Wrap-around: `reset_pc`=0xFE, ready=1: delivered PCs are 0xFE, 0xFF, 0x00, 0x01.
- Halt: assert `halt` for 4 cycles mid-stream at pc=10.
  - The in-flight word and buffered words still drain.
  - `mem_address` freezes, and delivery resumes at the next sequential PC with no gap in the instr_pc sequence.
  - Also check redirect together with halt: `pc` updates, nothing is issued until halt drops.
- Async reset mid-stream with FIFO full: `instr_valid` and `count` go to 0 and `mem_address` to `reset_pc` before the next clock edge; the 2-edge startup then repeats.
